sevenseg_scan: RTL

- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Consumes the latched per-digit segment patterns from the MMIO display register bank and drives one shared active-low segment bus plus one active-low anode line per digit.
- Inserts an anti-ghosting blank interval between digits, skips disabled digits, and optionally dims the display by PWM.

---
 rtl/sevenseg_scan.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional PWM dimming is enabled by defining SEVENSEG_SCAN_PWM_EN.
module sevenseg_scan #(
   parameter int DIGITS       = 8,
   parameter int SLOT_CYCLES  = 1024,
   parameter int BLANK_CYCLES = 16,
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7*DIGITS-1:0]   sevenseg,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic [3:0]            brightness,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic [DW-1:0]         digit,
   output logic                  frame_start,
   output logic [1:0]            scan_state
);

   localparam int DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
   localparam int CW = $clog2(SLOT_CYCLES);
   localparam logic [CW-1:0] LAST_SLOT  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);

   if (DRIVE_CYCLES % 16 != 0) begin : g_bad_drive
      $error("sevenseg_scan: SLOT_CYCLES-BLANK_CYCLES must be a multiple of 16");
   end
   if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
      $error("sevenseg_scan: DIGITS must be in 1..16");
   end
   if (BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT_CYCLES - 16) begin : g_bad_blank
      $error("sevenseg_scan: BLANK_CYCLES must be in 1..SLOT_CYCLES-16");
   end

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DARK  = 2'd2
   } state_t;

   state_t              state_q, state_n;
   logic [CW-1:0]       cnt_q, cnt_n;
   logic [DW-1:0]       digit_q, digit_n, next_digit, cand;
   logic [DIGITS-1:0]   an_q, an_n;
   logic [6:0]          seg_q, seg_n;
   logic                frame_q, frame_n;
   logic                found;
   logic                last_slot, last_blank, drive_done;
   logic [6:0]          pat [DIGITS];

   for (genvar g = 0; g < DIGITS; g++) begin : g_pat
      assign pat[g] = sevenseg[7*g +: 7];
   end

   assign last_slot  = (cnt_q == LAST_SLOT);
   assign last_blank = (cnt_q == LAST_BLANK);

`ifdef SEVENSEG_SCAN_PWM_EN
   localparam int ON_UNIT = DRIVE_CYCLES / 16;
   logic [3:0] bright_q;

   // Brightness is frozen together with the segment snapshot for the whole slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         bright_q <= 4'd0;
      end else if (state_q == ST_BLANK && last_blank) begin
         bright_q <= brightness;
      end
   end

   assign drive_done = (int'(cnt_q) == BLANK_CYCLES + ON_UNIT * (int'(bright_q) + 1) - 1);
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign drive_done = 1'b0;
`endif

   // Round-robin search starting after the current digit, ending on itself.
   always_comb begin
      next_digit = digit_q;
      found      = 1'b0;
      cand       = digit_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (cand == DW'(DIGITS - 1)) cand = '0;
         else                         cand = cand + 1'b1;
         if (!found && digit_en[cand]) begin
            next_digit = cand;
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q + 1'b1;
      digit_n = digit_q;
      an_n    = an_q;
      seg_n   = seg_q;
      frame_n = 1'b0;
      if (last_slot) begin
         cnt_n   = '0;
         state_n = ST_BLANK;
         an_n    = '1;
         seg_n   = 7'h7F;
         digit_n = next_digit;
         frame_n = (next_digit <= digit_q);
      end else begin
         case (state_q)
            ST_BLANK: begin
               an_n  = '1;
               seg_n = 7'h7F;
               if (last_blank) begin
                  if (digit_en[digit_q]) begin
                     state_n = ST_DRIVE;
                     an_n    = ~(DIGITS'(1) << digit_q);
                     seg_n   = pat[digit_q];
                  end else begin
                     state_n = ST_DARK;
                  end
               end
            end
            ST_DRIVE: begin
               if (!digit_en[digit_q] || drive_done) begin
                  state_n = ST_DARK;
                  an_n    = '1;
                  seg_n   = 7'h7F;
               end
            end
            default: begin
               state_n = ST_DARK;
               an_n    = '1;
               seg_n   = 7'h7F;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         digit_q <= '0;
         an_q    <= '1;
         seg_q   <= 7'h7F;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         digit_q <= digit_n;
         an_q    <= an_n;
         seg_q   <= seg_n;
         frame_q <= frame_n;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign digit       = digit_q;
   assign frame_start = frame_q;
   assign scan_state  = state_q;

endmodule
